// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle control FSM for the shared-ALU / shared-memory MIPS datapath.
//
// Each instruction walks FETCH -> DECODE -> (EXEC -> MEM_RD/MEM_WR -> WB | BRANCH | JUMP)
// and returns to FETCH. The datapath strobes are decoded from the current state and from
// the opcode/funct captured when the FSM enters DECODE. The only live inputs that reach the
// strobes are `zero` in BRANCH and `dm_ready` in MEM_WR.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   opcode, funct      instr[31:26] / instr[5:0] from the IR
//   zero               ALU zero flag (beq condition)
//   dm_ready           data memory finished the current read/write
//   pc_write, pc_src   PC load enable / next-PC select
//   ir_write           IR load enable
//   reg_write, reg_dst, jal, mem_to_reg   GRF write controls
//   mem_read, mem_write                   DM requests
//   alu_src, alu_control, ext_control     ALU operand / operation / immediate extension
//   state              current state code
//   instr_done         pulse in an instruction's final state
//   illegal            pulse in DECODE for an undecoded instruction
module mc_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               dm_ready,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               jal,
    output logic               mem_to_reg,
    output logic               mem_read,
    output logic               mem_write,
    output logic               alu_src,
    output logic [3:0]         alu_control,
    output logic               ext_control,
    output logic [STATE_W-1:0] state,
    output logic               instr_done,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_JUMP   = 3'd7
    } state_t;

    state_t     cur;
    logic [5:0] op_q;
    logic [5:0] fn_q;

    // Instruction class, decoded from the captured fields only, so IR updates
    // after DECODE cannot disturb an instruction already in flight.
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_exec, is_jmp;

    assign is_r    = (op_q == 6'b000000);
    assign is_addu = is_r && (fn_q == 6'b100001);
    assign is_subu = is_r && (fn_q == 6'b100011);
    assign is_jr   = is_r && (fn_q == 6'b001000);
    assign is_ori  = (op_q == 6'b001101);
    assign is_lui  = (op_q == 6'b001111);
    assign is_lw   = (op_q == 6'b100011);
    assign is_sw   = (op_q == 6'b101011);
    assign is_beq  = (op_q == 6'b000100);
    assign is_j    = (op_q == 6'b000010);
    assign is_jal  = (op_q == 6'b000011);
    assign is_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw;
    assign is_jmp  = is_j | is_jal | is_jr;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= S_FETCH;
            op_q <= 6'd0;
            fn_q <= 6'd0;
        end else begin
            case (cur)
                S_FETCH: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    cur  <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_exec)     cur <= S_EXEC;
                    else if (is_beq) cur <= S_BRANCH;
                    else if (is_jmp) cur <= S_JUMP;
                    else             cur <= S_FETCH;   // illegal: retire as a nop
                end
                S_EXEC: begin
                    if (is_lw)       cur <= S_MEM_RD;
                    else if (is_sw)  cur <= S_MEM_WR;
                    else             cur <= S_WB;
                end
                S_MEM_RD: if (dm_ready) cur <= S_WB;
                S_MEM_WR: if (dm_ready) cur <= S_FETCH;
                default:  cur <= S_FETCH;              // WB, BRANCH, JUMP are final states
            endcase
        end
    end

    // Reset forces every strobe low immediately, not just after the next edge,
    // so an aborted instruction cannot issue a write while reset is held.
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        jal         = 1'b0;
        mem_to_reg  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        alu_control = 4'b0000;
        ext_control = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        state       = '0;
        if (!reset) begin
            state = STATE_W'(cur);
            case (cur)
                S_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    if (!(is_exec | is_beq | is_jmp)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                // WB keeps the EXEC ALU settings so the result path stays stable
                // through the register write.
                S_EXEC, S_WB: begin
                    if (is_subu) begin
                        alu_control = 4'b0001;
                    end else if (is_ori) begin
                        alu_control = 4'b0010;
                        alu_src     = 1'b1;
                    end else if (is_lui) begin
                        alu_control = 4'b0011;
                        alu_src     = 1'b1;
                    end else if (is_lw | is_sw) begin
                        alu_src     = 1'b1;
                        ext_control = 1'b1;
                    end
                    if (cur == S_WB) begin
                        reg_write  = 1'b1;
                        instr_done = 1'b1;
                        reg_dst    = is_r;
                        mem_to_reg = is_lw;
                    end
                end
                S_MEM_RD: mem_read = 1'b1;
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    instr_done = dm_ready;
                end
                S_BRANCH: begin
                    alu_control = 4'b0001;
                    ext_control = 1'b1;
                    pc_src      = 2'b01;
                    pc_write    = zero;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    pc_src     = is_jr ? 2'b11 : 2'b10;
                    jal        = is_jal;
                    reg_write  = is_jal;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios followed by random instruction streams, each
// checked cycle by cycle against an instruction-level model (expected state walk per
// instruction class plus the strobe table for each phase).
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       dm_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, reg_dst, jal, mem_to_reg;
    logic       mem_read, mem_write, alu_src, ext_control, instr_done, illegal;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic [2:0] state;

    mc_ctrl #(.STATE_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .dm_ready(dm_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .jal(jal), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
        .alu_control(alu_control), .ext_control(ext_control), .state(state),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                      K_J, K_JAL, K_JR, K_ILL} kind_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [17:0] obs_vec();
        return {pc_write, pc_src, ir_write, reg_write, reg_dst, jal, mem_to_reg,
                mem_read, mem_write, alu_src, alu_control, ext_control, instr_done, illegal};
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b100001) return K_ADDU;
                if (fn == 6'b100011) return K_SUBU;
                if (fn == 6'b001000) return K_JR;
                return K_ILL;
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    // Expected strobes for instruction class k while in state st.
    function automatic logic [17:0] exp_vec(input kind_t k, input int st,
                                            input logic z, input logic dmr);
        logic pw, iw, rw, rd, jl, m2r, mr, mw, as_, ex, done, ill;
        logic [1:0] ps;
        logic [3:0] ac;
        {pw, iw, rw, rd, jl, m2r, mr, mw, as_, ex, done, ill} = '0;
        ps = 2'b00;
        ac = 4'b0000;
        case (st)
            0: begin iw = 1'b1; pw = 1'b1; end
            1: if (k == K_ILL) begin ill = 1'b1; done = 1'b1; end
            2, 5: begin
                case (k)
                    K_SUBU:     ac = 4'b0001;
                    K_ORI:      begin ac = 4'b0010; as_ = 1'b1; end
                    K_LUI:      begin ac = 4'b0011; as_ = 1'b1; end
                    K_LW, K_SW: begin as_ = 1'b1; ex = 1'b1; end
                    default: ;
                endcase
                if (st == 5) begin
                    rw = 1'b1; done = 1'b1;
                    rd = (k == K_ADDU) || (k == K_SUBU);
                    m2r = (k == K_LW);
                end
            end
            3: mr = 1'b1;
            4: begin mw = 1'b1; done = dmr; end
            6: begin ac = 4'b0001; ex = 1'b1; ps = 2'b01; pw = z; done = 1'b1; end
            7: begin
                pw = 1'b1; done = 1'b1;
                ps = (k == K_JR) ? 2'b11 : 2'b10;
                jl = (k == K_JAL); rw = (k == K_JAL);
            end
            default: ;
        endcase
        return {pw, ps, iw, rw, rd, jl, m2r, mr, mw, as_, ac, ex, done, ill};
    endfunction

    // Run one instruction from its FETCH cycle. skip: already inside the FETCH cycle
    // (just past the negedge). abort_at: stop after this many cycles (-1 runs it all).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                             input logic zv, input bit skip, input int abort_at);
        kind_t k;
        int    seq[$];
        int    mi;
        k = classify(op, fn);
        seq = {0, 1};
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: seq = {seq, 2, 5};
            K_LW: begin
                seq.push_back(2);
                for (int i = 0; i <= waits; i++) seq.push_back(3);
                seq.push_back(5);
            end
            K_SW: begin
                seq.push_back(2);
                for (int i = 0; i <= waits; i++) seq.push_back(4);
            end
            K_BEQ: seq.push_back(6);
            K_ILL: ;
            default: seq.push_back(7);
        endcase
        mi = 0;
        for (int idx = 0; idx < seq.size(); idx++) begin
            if (idx == abort_at) break;
            if (!(skip && idx == 0)) @(negedge clk);
            if (idx == 0) begin
                opcode = op; funct = fn;
            end else begin
                opcode = 6'($urandom); funct = 6'($urandom);   // must not matter now
            end
            zero = zv;
            if (seq[idx] == 3 || seq[idx] == 4) begin
                dm_ready = (mi == waits);
                mi++;
            end else begin
                dm_ready = 1'($urandom_range(0, 1));
            end
            #1;
            chk($sformatf("state k%0d c%0d", int'(k), idx), 32'(state), 32'(seq[idx]));
            chk($sformatf("outs k%0d st%0d c%0d", int'(k), seq[idx], idx), 32'(obs_vec()),
                32'(exp_vec(k, seq[idx], zv, dm_ready)));
        end
    endtask

    task automatic pick(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            K_JR:   begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                op = 6'($urandom);
                while (classify(op, fn) != K_ILL) begin
                    op = 6'($urandom); fn = 6'($urandom);
                end
            end
        endcase
    endtask

    initial begin
        logic [5:0] op, fn;
        kind_t k;

        // Power-up reset: everything quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_outs", 32'(obs_vec()), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
        end

        // addu interrupted by a 2-cycle reset in EXEC.
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'b000000, 6'b100001, 0, 1'b0, 1'b1, 3);
        reset = 1'b1;
        #1;
        chk("abort_outs0", 32'(obs_vec()), 32'd0);
        chk("abort_state0", 32'(state), 32'd0);
        @(negedge clk); #1;
        chk("abort_outs1", 32'(obs_vec()), 32'd0);
        chk("abort_state1", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'b000000, 6'b100001, 0, 1'b0, 1'b1, -1);   // full addu from FETCH

        // Directed cases.
        run_instr(6'b100011, 6'd0, 3, 1'b0, 1'b0, -1);          // lw, 3 waits
        run_instr(6'b101011, 6'd5, 0, 1'b0, 1'b0, -1);          // sw, ready at once
        run_instr(6'b000100, 6'd0, 0, 1'b1, 1'b0, -1);          // beq taken
        run_instr(6'b000100, 6'd0, 0, 1'b0, 1'b0, -1);          // beq not taken
        run_instr(6'b000011, 6'd0, 0, 1'b0, 1'b0, -1);          // jal
        run_instr(6'b111111, 6'd0, 0, 1'b0, 1'b0, -1);          // illegal
        run_instr(6'b000000, 6'b001000, 0, 1'b0, 1'b0, -1);     // jr
        run_instr(6'b000000, 6'b000000, 0, 1'b0, 1'b0, -1);     // R-type bad funct

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            k = kind_t'($urandom_range(0, 10));
            pick(k, op, fn);
            run_instr(op, fn, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'b0, -1);
        end

        @(negedge clk); #1;
        chk("final_fetch", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the next revision of the MIPS datapath, in which one ALU and one memory port are shared across instruction phases.
- Sequences each instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and drives every datapath strobe and mux select.
- Stalls on a variable-latency data-memory handshake.
- Sits beside the GRF, ALU, DM and the PC/IR registers, and replaces the single-cycle ctrl decoder.

Parameters:
- STATE_W, 3, width of the exported state code.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; one clock domain.
- opcode  input  6  instr[31:26] from the IR.
- funct  input  6  instr[5:0] from the IR.
- zero  input  1  ALU zero flag.
- dm_ready  input  1  data memory has completed the current read or write.
- pc_write  output  1  PC register load enable.
- pc_src  output  2  next-PC select: 00 ALU pc+4, 01 branch target, 10 jump target {pc[31:28],instr[25:0],00}, 11 GPR[rs].
- ir_write  output  1  IR load enable.
- reg_write  output  1  GRF write enable.
- reg_dst  output  1  1 selects rd, 0 selects rt (ignored when jal=1).
- jal  output  1  write $31 with the PC value.
- mem_to_reg  output  1  write-back data from DM.
- mem_read  output  1  DM read request.
- mem_write  output  1  DM write request.
- alu_src  output  1  1 selects extended immediate as ALU B.
- alu_control  output  4  0000 add, 0001 sub, 0010 or, 0011 lui (B<<16).
- ext_control  output  1  1 sign-extend, 0 zero-extend.
- state  output  STATE_W  current state code.
- instr_done  output  1  one-cycle pulse in an instruction's final state.
- illegal  output  1  one-cycle pulse on an undecoded opcode/funct.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, BRANCH=6, JUMP=7.
- Reset (sampled at posedge):
  - state <= FETCH; latched opcode/funct cleared.
  - Every output is 0 while reset=1, overriding state decode.
  - Reset mid-instruction aborts that instruction with no further writes.
- Outputs are Moore: decoded from state plus the opcode/funct latched on entry to DECODE. IR changes after DECODE have no effect.
- FETCH: ir_write=1, pc_write=1, pc_src=00. Next state is always DECODE.
- DECODE:
  - R-type addu (000000/100001) and subu (000000/100011), ori 001101, lui 001111 -> EXEC.
  - lw 100011, sw 101011 -> EXEC.
  - beq 000100 -> BRANCH.
  - j 000010, jal 000011, jr (000000/001000) -> JUMP.
  - Any other opcode/funct: illegal=1, instr_done=1, next state FETCH; the instruction executes as a nop.
- EXEC:
  - addu: alu_control=0000, alu_src=0.
  - subu: alu_control=0001, alu_src=0.
  - ori: alu_control=0010, alu_src=1, ext_control=0.
  - lui: alu_control=0011, alu_src=1.
  - lw/sw: alu_control=0000, alu_src=1, ext_control=1.
  - Next state: MEM_RD for lw, MEM_WR for sw, otherwise WB.
- MEM_RD: mem_read=1. Stay in MEM_RD while dm_ready=0; go to WB on dm_ready=1.
- MEM_WR:
  - mem_write=1, held while dm_ready=0.
  - On dm_ready=1: instr_done=1, next state FETCH.
  - The write commits exactly once, in the dm_ready=1 cycle.
- WB:
  - reg_write=1 and instr_done=1; next state FETCH.
  - R-type: reg_dst=1. ori/lui: reg_dst=0. lw: reg_dst=0, mem_to_reg=1.
  - EXEC-stage ALU controls are held during WB.
- BRANCH:
  - alu_control=0001, alu_src=0, ext_control=1, pc_src=01, pc_write=zero, instr_done=1.
  - Next state FETCH.
- JUMP:
  - pc_write=1 and instr_done=1; next state FETCH.
  - pc_src=10 for j/jal, 11 for jr.
  - jal additionally drives jal=1 and reg_write=1 (writes $31 with the already-incremented PC).
- Latency in cycles:
  - addu/subu/ori/lui: 4. sw: 4 + waits. lw: 5 + waits.
  - beq, j, jal, jr: 3. Illegal: 2.
- Boundaries:
  - dm_ready asserted outside MEM_RD/MEM_WR is ignored.
  - dm_ready already high on entry to a MEM state gives zero wait cycles.
  - A write to $0 is still strobed; the GRF masks it.
  - At most one of mem_read/mem_write/reg_write/pc_write-for-branch is active per non-FETCH state, except JUMP with jal, where pc_write and reg_write are both active.

Test Plan:
- Reset held 2 cycles mid-EXEC of addu, then released -> all outputs 0 during reset; state=0 on the next cycle with ir_write=1, pc_write=1; no reg_write pulse from the aborted addu.
- addu (000000/100001) -> state sequence 0,1,2,5,0; reg_write=1, reg_dst=1 only in WB; instr_done pulses once; 4 cycles total.
- lw (100011) with dm_ready low for 3 cycles in MEM_RD -> sequence 0,1,2,3,3,3,3,5,0; mem_read high for all 4 MEM_RD cycles; mem_to_reg=1 in WB; 8 cycles total.
- sw (101011) with dm_ready=1 immediately -> mem_write high exactly 1 cycle; reg_write never asserted; 4 cycles total.
- beq (000100) run twice, once with zero=1 and once with zero=0 -> pc_write=1/pc_src=01 in BRANCH only when zero=1; 3 cycles each.
- jal (000011), then opcode 111111 -> JUMP state asserts pc_write=1, pc_src=10, jal=1, reg_write=1; the next instruction pulses illegal=1 in DECODE and returns to FETCH after 2 cycles with no writes.
